inertial_integrator: RTL
========================

Name: inertial_integrator

Overview:
- Upstream neighbour of the balance PID.
- Takes raw gyro pitch-rate and Z-accelerometer samples from the inertial SPI front end.
- Runs a start-up offset calibration, then integrates the offset-corrected pitch rate into a pitch estimate. Accelerometer-derived pitch corrects long-term drift (complementary fusion).
- Produces ptch, ptch_rt and a valid strobe that feed the PID's ptch, ptch_rt and vld inputs directly.

Parameters:
- CAL_SHIFT, 4: log2 of calibration sample count; 2^CAL_SHIFT samples are averaged.
- FUSION_GAIN, 1024: magnitude added to or subtracted from the integrator per sample for accel correction.
- AZ_SCALE, 327: signed multiplier converting offset-corrected AZ to pitch units before the >>>13.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- vld  in  1  one-cycle strobe: new ptch_rt_raw/AZ_raw sample valid
- ptch_rt_raw  in  16  signed raw gyro pitch rate
- AZ_raw  in  16  signed raw Z acceleration
- recal  in  1  synchronous request to restart calibration
- ptch  out  16  signed fused pitch estimate, = integ[26:11]
- ptch_rt  out  16  signed offset-corrected pitch rate (registered)
- ptch_vld  out  1  one-cycle strobe: ptch/ptch_rt updated
- cal_done  out  1  high while in RUN

Behaviour:
- Decided: clock clk; reset rst_n, asynchronous, active-low. All flops are reset by it.
- Reset values: state=CAL, cnt=0, both sums=0, rt_off=0, az_off=0, integ(27b)=0, ptch_rt=0, ptch_vld=0, cal_done=0, and pipeline regs=0.
- FSM states:
  - CAL:
    - On each vld, add sign-extended samples into signed (16+CAL_SHIFT)-bit sums and increment cnt.
    - On the vld where cnt==2^CAL_SHIFT-1: rt_off = rt_sum_final>>>CAL_SHIFT and az_off likewise. Sums include the current sample; arithmetic shift floors. Clear cnt and sums, go to RUN on the same edge.
    - In CAL: integ held 0, ptch_vld=0, ptch_rt=0.
  - RUN (cal_done=1):
    - Stage 1, on vld: rt_c = ptch_rt_raw - rt_off; az_c = AZ_raw - az_off. Both 16-bit wrapping. Register rt_c, az_c and v1=1.
    - Stage 2, on v1:
      - prod = az_c*AZ_SCALE, 26-bit signed.
      - ptch_acc = prod[25:13] sign-extended to 16.
      - If ptch_acc > ptch (signed compare, pre-update ptch): integ += FUSION_GAIN; else integ -= FUSION_GAIN.
      - Also integ -= sign-extended rt_c.
      - 27-bit wraparound, no saturation.
      - ptch_rt <= rt_c; ptch_vld <= 1 for one cycle.
- Latency: vld sampled at edge N → integ/ptch/ptch_rt/ptch_vld updated at edge N+1. ptch_vld is high for the cycle after N+1.
- vld on back-to-back cycles is legal; each sample is processed, throughput 1/clk.
- recal:
  - Any state, synchronous, highest priority.
  - Go to CAL; clear cnt, sums, integ and pipeline v1. ptch_vld=0 next cycle; cal_done=0.
  - Offsets are retained until the new calibration completes.
  - A vld coincident with recal is discarded.
- Reset mid-calibration or mid-pipeline: everything returns to reset values; no partial sample survives.

Test Plan:
- Calibration: 16 vld with ptch_rt_raw=0x0050, AZ_raw=0x0000 → rt_off=0x0050, az_off=0, cal_done rises the cycle after the 16th vld, and ptch_vld never pulses during CAL.
- Drift correction: after calibration, apply ptch_rt_raw=0x0050, AZ_raw=0. Required sequence:
  - 1st sample: ptch=0xFFFF (integ=-1024).
  - 2nd sample: ptch=0 (integ=0).
  - Output alternates thereafter; ptch_rt=0 each time; ptch_vld exactly one cycle, 2 clocks after each vld.
- Integration: after calibration, apply ptch_rt_raw=0xF850 (rt_c=-2048), AZ_raw=0 → integ grows +1024 per sample. After 20 samples integ=20480, ptch=10; ptch_rt=0xF800.
- Accel scale: az_off=0, AZ_raw=0x0800 → prod=669696, ptch_acc=81. With ptch=0 and rt_c=0, integ increments +1024 per sample.
- Calibration with negative values: 16 samples alternating ptch_rt_raw=-3/-4 → rt_sum=-56, rt_off=-4 (floor).
- Disruptions:
  - Assert recal in RUN with integ≠0 → next cycle integ=0, cal_done=0, no ptch_vld for the next 16 vld.
  - Assert rst_n low after 7 CAL samples → cnt=0, and 16 fresh samples are needed after release.

Source files
------------

// File: rtl/inertial_integrator.sv
// Pitch estimator: averages gyro/accel offsets at start-up, then integrates the
// corrected pitch rate and nudges the integrator toward accel-derived pitch.
module inertial_integrator #(
  parameter int CAL_SHIFT   = 4,
  parameter int FUSION_GAIN = 1024,
  parameter int AZ_SCALE    = 327
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vld,
  input  logic signed [15:0] ptch_rt_raw,
  input  logic signed [15:0] AZ_raw,
  input  logic               recal,
  output logic signed [15:0] ptch,
  output logic signed [15:0] ptch_rt,
  output logic               ptch_vld,
  output logic               cal_done
);
  localparam int SW = 16 + CAL_SHIFT;
  localparam logic signed [26:0] GAIN  = 27'(FUSION_GAIN);
  localparam logic signed [25:0] SCALE = 26'(AZ_SCALE);

  typedef enum logic {CAL, RUN} state_t;
  state_t r_state, w_next;

  logic [CAL_SHIFT-1:0] r_cnt;
  logic signed [SW-1:0] r_rt_sum, r_az_sum, w_rt_sum, w_az_sum, w_rt_avg, w_az_avg;
  logic signed [15:0]   r_rt_off, r_az_off, r_rt_c, r_az_c, r_ptch_rt;
  logic                 r_v1, r_ptch_vld, w_cal_last;
  logic signed [26:0]   r_integ, w_integ;
  logic signed [25:0]   w_prod;
  logic signed [15:0]   w_ptch_acc;

  // Running calibration sums include the sample arriving this cycle
  assign w_rt_sum   = r_rt_sum + $signed({{CAL_SHIFT{ptch_rt_raw[15]}}, ptch_rt_raw});
  assign w_az_sum   = r_az_sum + $signed({{CAL_SHIFT{AZ_raw[15]}}, AZ_raw});
  assign w_rt_avg   = w_rt_sum >>> CAL_SHIFT;
  assign w_az_avg   = w_az_sum >>> CAL_SHIFT;
  assign w_cal_last = (r_state == CAL) && vld && (r_cnt == {CAL_SHIFT{1'b1}});

  // Accel pitch pulls the integrator up or down by a fixed step each sample
  assign w_prod     = $signed({{10{r_az_c[15]}}, r_az_c}) * SCALE;
  assign w_ptch_acc = $signed({{3{w_prod[25]}}, w_prod[25:13]});
  assign w_integ    = r_integ + ((w_ptch_acc > ptch) ? GAIN : -GAIN)
                      - $signed({{11{r_rt_c[15]}}, r_rt_c});

  assign ptch     = r_integ[26:11];
  assign ptch_rt  = r_ptch_rt;
  assign ptch_vld = r_ptch_vld;
  assign cal_done = (r_state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= CAL;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (recal)           w_next = CAL;
    else if (w_cal_last) w_next = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_rt_sum   <= '0;
      r_az_sum   <= '0;
      r_rt_off   <= '0;
      r_az_off   <= '0;
      r_rt_c     <= '0;
      r_az_c     <= '0;
      r_v1       <= 1'b0;
      r_integ    <= '0;
      r_ptch_rt  <= '0;
      r_ptch_vld <= 1'b0;
    end else if (recal) begin
      // Offsets survive a recalibration until the new ones are ready
      r_cnt      <= '0;
      r_rt_sum   <= '0;
      r_az_sum   <= '0;
      r_v1       <= 1'b0;
      r_integ    <= '0;
      r_ptch_rt  <= '0;
      r_ptch_vld <= 1'b0;
    end else begin
      r_v1       <= 1'b0;
      r_ptch_vld <= 1'b0;
      if (r_state == CAL) begin
        if (w_cal_last) begin
          r_rt_off <= w_rt_avg[15:0];
          r_az_off <= w_az_avg[15:0];
          r_cnt    <= '0;
          r_rt_sum <= '0;
          r_az_sum <= '0;
        end else if (vld) begin
          r_cnt    <= r_cnt + 1'b1;
          r_rt_sum <= w_rt_sum;
          r_az_sum <= w_az_sum;
        end
      end else begin
        if (vld) begin
          r_rt_c <= ptch_rt_raw - r_rt_off;
          r_az_c <= AZ_raw - r_az_off;
          r_v1   <= 1'b1;
        end
        if (r_v1) begin
          r_integ    <= w_integ;
          r_ptch_rt  <= r_rt_c;
          r_ptch_vld <= 1'b1;
        end
      end
    end
  end

endmodule
